// File: rtl/digit_serial_subtractor.sv
// digit_serial_subtractor
//
// Digit-serial unsigned subtractor computing d = x - y - z (mod 2^WIDTH)
// with borrow-out b. One operand set is processed DIGIT bits per clock,
// least-significant digit first. There are N = WIDTH/DIGIT steps, so the
// result appears N cycles after the operands are accepted.
//
// Parameters:
//   WIDTH     operand width in bits (default 16)
//   DIGIT     bits processed per cycle (default 4). WIDTH must be an integer
//             multiple of DIGIT, and DIGIT must be at least 1.
//
// Ports:
//   clk        clock; all state changes happen on its rising edge
//   rst        synchronous, active-high reset
//   in_valid   an operand set (x, y, z) is present
//   in_ready   the block can accept an operand set (high only in IDLE)
//   x, y       minuend and subtrahend, WIDTH bits each
//   z          borrow-in
//   out_valid  the result (d, b) is valid
//   out_ready  the consumer accepts the result
//   d          difference, WIDTH bits
//   b          borrow-out; 1 when x < y + z (unsigned)
//   v          (only with SUBTRACTOR_OVERFLOW_EN) signed two's-complement
//              overflow, valid and held together with d
//
// Optional feature macro: SUBTRACTOR_OVERFLOW_EN adds the overflow output v.

`timescale 1ns/1ps

module digit_serial_subtractor #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             b
`ifdef SUBTRACTOR_OVERFLOW_EN
    ,
    output logic             v
`endif
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg;
    logic [WIDTH-1:0]   x_reg;
    logic [WIDTH-1:0]   y_reg;
    logic               borrow_reg;
    logic [CNT_W-1:0]   cnt_reg;

    // One-digit subtract. The extra top bit of the (DIGIT+1)-bit result
    // becomes 1 exactly when the digit underflows, i.e. it is the borrow.
    logic [DIGIT:0]     dig_full;
    logic [DIGIT-1:0]   dig_diff;
    logic               dig_borrow;
    logic [WIDTH-1:0]   x_next;

    assign dig_full   = {1'b0, x_reg[DIGIT-1:0]}
                      - {1'b0, y_reg[DIGIT-1:0]}
                      - {{DIGIT{1'b0}}, borrow_reg};
    assign dig_diff   = dig_full[DIGIT-1:0];
    assign dig_borrow = dig_full[DIGIT];

    // The minuend register doubles as the result accumulator: each step
    // shifts the consumed digit out at the bottom and inserts the new
    // difference digit at the top. After N steps it holds the full result.
    generate
        if (DIGIT == WIDTH) begin : g_single
            assign x_next = dig_diff;
        end else begin : g_multi
            assign x_next = {dig_diff, x_reg[WIDTH-1:DIGIT]};
        end
    endgenerate

`ifdef SUBTRACTOR_OVERFLOW_EN
    // Operand sign bits, kept because x_reg/y_reg are shifted away.
    logic x_sign_reg;
    logic y_sign_reg;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            d          <= '0;
            b          <= 1'b0;
            x_reg      <= '0;
            y_reg      <= '0;
            borrow_reg <= 1'b0;
            cnt_reg    <= '0;
`ifdef SUBTRACTOR_OVERFLOW_EN
            v          <= 1'b0;
            x_sign_reg <= 1'b0;
            y_sign_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        x_reg      <= x;
                        y_reg      <= y;
                        borrow_reg <= z;
                        cnt_reg    <= '0;
                        in_ready   <= 1'b0;
                        state_reg  <= RUN;
`ifdef SUBTRACTOR_OVERFLOW_EN
                        x_sign_reg <= x[WIDTH-1];
                        y_sign_reg <= y[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    x_reg      <= x_next;
                    y_reg      <= y_reg >> DIGIT;
                    borrow_reg <= dig_borrow;
                    cnt_reg    <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST) begin
                        d         <= x_next;
                        b         <= dig_borrow;
                        out_valid <= 1'b1;
                        state_reg <= DONE;
`ifdef SUBTRACTOR_OVERFLOW_EN
                        // dig_diff[DIGIT-1] is the result's sign bit here.
                        v <= (x_sign_reg != y_sign_reg)
                          && (dig_diff[DIGIT-1] != x_sign_reg);
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digit_serial_subtractor.sv
// tb_digit_serial_subtractor
//
// Directed self-checking bench for digit_serial_subtractor. Instance dut
// uses WIDTH=16, DIGIT=4; instance dut1 uses WIDTH=16, DIGIT=1.

`timescale 1ns/1ps

module tb_digit_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid, in_ready, z, out_valid, out_ready, b;
    logic [15:0] x, y, d;
    logic        in_valid1, in_ready1, z1, out_valid1, out_ready1, b1;
    logic [15:0] x1, y1, d1;
`ifdef SUBTRACTOR_OVERFLOW_EN
    logic        v, v1;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    digit_serial_subtractor #(.WIDTH(16), .DIGIT(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .z(z),
        .out_valid(out_valid), .out_ready(out_ready),
        .d(d), .b(b)
`ifdef SUBTRACTOR_OVERFLOW_EN
        , .v(v)
`endif
    );

    digit_serial_subtractor #(.WIDTH(16), .DIGIT(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .x(x1), .y(y1), .z(z1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .d(d1), .b(b1)
`ifdef SUBTRACTOR_OVERFLOW_EN
        , .v(v1)
`endif
    );

    // Present one operand set to dut for exactly one edge (the accept edge).
    task automatic start_op(input logic [15:0] xa, input logic [15:0] ya, input logic za);
        x = xa; y = ya; z = za; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count cycles after the accept edge until out_valid; bounded.
    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 100) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else pass_cnt++;
        total_cnt++; if (d !== 16'h0000 || b !== 1'b0) $display("FAIL reset_d_b got=%h/%b exp=0000/0", d, b); else pass_cnt++;
        total_cnt++; if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0) $display("FAIL reset_dut1 got=%b/%b exp=1/0", in_ready1, out_valid1); else pass_cnt++;
        $display("reset done");
    endtask

    task automatic test_basic();
        int cyc;
        start_op(16'h0000, 16'h0001, 1'b0);
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL basic_in_ready_run got=%b exp=0", in_ready); else pass_cnt++;
        wait_valid(cyc);
        total_cnt++; if (cyc !== 4) $display("FAIL basic_latency got=%0d exp=4", cyc); else pass_cnt++;
        total_cnt++; if (d !== 16'hFFFF || b !== 1'b1) $display("FAIL basic_result got=%h/%b exp=ffff/1", d, b); else pass_cnt++;
        $display("op x=0000 y=0001 z=0 -> d=%h b=%b after %0d cycles", d, b, cyc);
        consume();
    endtask

    task automatic test_vectors();
        int cyc;
        start_op(16'hFFFF, 16'hFFFF, 1'b1);
        wait_valid(cyc);
        total_cnt++; if (d !== 16'hFFFF || b !== 1'b1) $display("FAIL vec_ffff got=%h/%b exp=ffff/1", d, b); else pass_cnt++;
`ifdef SUBTRACTOR_OVERFLOW_EN
        total_cnt++; if (v !== 1'b0) $display("FAIL vec_ffff_v got=%b exp=0", v); else pass_cnt++;
`endif
        $display("op x=ffff y=ffff z=1 -> d=%h b=%b", d, b);
        consume();
        start_op(16'h1234, 16'h0234, 1'b0);
        wait_valid(cyc);
        total_cnt++; if (d !== 16'h1000 || b !== 1'b0) $display("FAIL vec_1234 got=%h/%b exp=1000/0", d, b); else pass_cnt++;
        $display("op x=1234 y=0234 z=0 -> d=%h b=%b", d, b);
        consume();
        start_op(16'h8000, 16'h0001, 1'b0);
        wait_valid(cyc);
        total_cnt++; if (d !== 16'h7FFF || b !== 1'b0) $display("FAIL vec_8000 got=%h/%b exp=7fff/0", d, b); else pass_cnt++;
`ifdef SUBTRACTOR_OVERFLOW_EN
        total_cnt++; if (v !== 1'b1) $display("FAIL vec_8000_v got=%b exp=1", v); else pass_cnt++;
`endif
        $display("op x=8000 y=0001 z=0 -> d=%h b=%b", d, b);
        consume();
    endtask

    task automatic test_backpressure();
        int cyc;
        int bad;
        start_op(16'h1234, 16'h0234, 1'b0);
        wait_valid(cyc);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b1 || d !== 16'h1000 || b !== 1'b0 || in_ready !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        total_cnt++; if (bad != 0) $display("FAIL hold_stable got=%0d_bad_cycles exp=0 (d=%h b=%b ov=%b ir=%b)", bad, d, b, out_valid, in_ready); else pass_cnt++;
        consume();
        total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL release_idle got=%b/%b exp=0/1", out_valid, in_ready); else pass_cnt++;
        total_cnt++; if (d !== 16'h1000) $display("FAIL release_d_hold got=%h exp=1000", d); else pass_cnt++;
        $display("op held 5 cycles then consumed d=%h", d);
    endtask

    task automatic test_abort();
        int cyc;
        int seen;
        start_op(16'h0005, 16'h0003, 1'b0);
        @(posedge clk); #1;          // first RUN edge
        rst = 1'b1;
        @(posedge clk); #1;          // second RUN edge, reset wins
        rst = 1'b0;
        total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || d !== 16'h0000 || b !== 1'b0)
            $display("FAIL abort_state got=ov%b ir%b d%h b%b exp=ov0 ir1 d0000 b0", out_valid, in_ready, d, b); else pass_cnt++;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        total_cnt++; if (seen != 0) $display("FAIL abort_no_valid got=%0d exp=0", seen); else pass_cnt++;
        start_op(16'h0010, 16'h0020, 1'b0);
        wait_valid(cyc);
        total_cnt++; if (cyc !== 4 || d !== 16'hFFF0 || b !== 1'b1) $display("FAIL abort_reuse got=%0d/%h/%b exp=4/fff0/1", cyc, d, b); else pass_cnt++;
        $display("op after abort x=0010 y=0020 -> d=%h b=%b", d, b);
        consume();
    endtask

    task automatic test_operand_change();
        int cyc;
        start_op(16'h5678, 16'h1234, 1'b1);
        for (int i = 0; i < 4; i++) begin
            x = 16'($urandom); y = 16'($urandom); z = 1'($urandom); in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        cyc = 4;
        total_cnt++; if (out_valid !== 1'b1 || d !== 16'h4443 || b !== 1'b0) $display("FAIL operand_change got=%b/%h/%b exp=1/4443/0", out_valid, d, b); else pass_cnt++;
        $display("op x=5678 y=1234 z=1 with noisy inputs -> d=%h b=%b", d, b);
        consume();
    endtask

    task automatic test_digit1();
        int cyc;
        x1 = 16'h8000; y1 = 16'h0001; z1 = 1'b0; in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        cyc = 0;
        while (!out_valid1 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        total_cnt++; if (cyc !== 16) $display("FAIL digit1_latency got=%0d exp=16", cyc); else pass_cnt++;
        total_cnt++; if (d1 !== 16'h7FFF || b1 !== 1'b0) $display("FAIL digit1_result got=%h/%b exp=7fff/0", d1, b1); else pass_cnt++;
`ifdef SUBTRACTOR_OVERFLOW_EN
        total_cnt++; if (v1 !== 1'b1) $display("FAIL digit1_v got=%b exp=1", v1); else pass_cnt++;
`endif
        $display("op dut1 x=8000 y=0001 z=0 -> d=%h b=%b after %0d cycles", d1, b1, cyc);
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        out_ready1 = 1'b0;
        total_cnt++; if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0) $display("FAIL digit1_release got=%b/%b exp=1/0", in_ready1, out_valid1); else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; x = '0; y = '0; z = 1'b0; out_ready = 1'b0;
        in_valid1 = 1'b0; x1 = '0; y1 = '0; z1 = 1'b0; out_ready1 = 1'b0;
        test_reset();
        test_basic();
        test_vectors();
        test_backpressure();
        test_abort();
        test_operand_change();
        test_digit1();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
